// File: rtl/conv_result_reader.sv
// conv_result_reader: drains the convolution result memory filter by filter
// and streams each word over a valid/ready interface.
// Optional build macro: CONV_RESULT_RELU_EN (clamp negative results to zero
// at capture). Default build passes results through unchanged.

module conv_result_reader #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned OUT_SIZE    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_filter,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned ELEM_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_FIN     = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Drain context: latched base and the indices of the word in flight.
  logic [ADDR_W-1:0] base_q, base_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [ELEM_W-1:0] elem_q, elem_d;

  // Registered outputs.
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        out_filter_q, out_filter_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs_c;
  logic              last_c;
  logic              elem_wrap_c;
  logic [DATA_W-1:0] capture_c;
  logic [31:0]       offset_c;

  assign hs_c        = out_valid_q && out_ready;
  assign elem_wrap_c = (elem_q == ELEM_W'(OUT_SIZE - 1));
  assign last_c      = (filt_q == FILT_W'(NUM_FILTERS - 1)) && elem_wrap_c;

  // Capture-path data conditioning (optional ReLU clamp).
  always_comb begin
`ifdef CONV_RESULT_RELU_EN
    capture_c = mem_rdata[DATA_W-1] ? '0 : mem_rdata;
`else
    capture_c = mem_rdata;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT: begin
        if (hs_c) state_d = out_last_q ? S_FIN : S_FETCH;
      end
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values, derived from current and next state.
  always_comb begin
    base_d       = base_q;
    filt_d       = filt_q;
    elem_d       = elem_q;
    out_data_d   = out_data_q;
    out_filter_d = out_filter_q;
    out_last_d   = out_last_q;
    offset_c     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          filt_d = '0;
          elem_d = '0;
        end
      end
      S_CAPTURE: begin
        out_data_d   = capture_c;
        out_filter_d = 8'(filt_q);
        out_last_d   = last_c;
      end
      S_OUT: begin
        if (hs_c && !out_last_q) begin
          if (elem_wrap_c) begin
            elem_d = '0;
            filt_d = filt_q + FILT_W'(1);
          end else begin
            elem_d = elem_q + ELEM_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Read address wraps modulo the address space.
    offset_c    = 32'(filt_d) * 32'(OUT_SIZE) + 32'(elem_d);
    mem_rd_en_d = (state_d == S_FETCH);
    mem_addr_d  = (state_d == S_FETCH) ? (base_d + offset_c[ADDR_W-1:0]) : mem_addr_q;
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
  end

  // Datapath and output registers; reset aborts any drain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      filt_q       <= '0;
      elem_q       <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_filter_q <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      base_q       <= base_d;
      filt_q       <= filt_d;
      elem_q       <= elem_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_filter_q <= out_filter_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_filter = out_filter_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: table of drain scenarios checked through a
// scoreboard of expected words and read addresses, plus a reset-abort sequence.

module tb_conv_result_reader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NF     = 4;
  localparam int unsigned OS     = 16;
  localparam int NW = NF * OS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_filter;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  conv_result_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FILTERS(NF), .OUT_SIZE(OS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filter(out_filter), .out_last(out_last), .busy(busy), .done(done)
  );

  // Result memory model with one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [7:0] data;
    logic [7:0] filt;
    logic       last;
  } word_t;

  typedef struct {
    string      name;
    logic [7:0] base;
    int         mode;
    int         stall_word;
    int         stall_len;
    bit         ign_start;
    int         exp_done_n;
  } vec_t;

  word_t      exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] got_data [NW];
  logic [7:0] rd_log [NW];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [7:0] model(input logic [7:0] v);
`ifdef CONV_RESULT_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_mem(input logic [7:0] base, input int mode);
    logic [7:0] a;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h5A;
    if (mode == 0) begin
      for (int i = 0; i < NW; i++) begin
        a = base + 8'(i);
        mem[a] = 8'(i);
      end
    end else if (mode == 2) begin
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom_range(0, 255));
      a = base;          mem[a] = 8'h85;
      a = base + 8'd1;   mem[a] = 8'h7F;
      a = base + 8'd2;   mem[a] = 8'h00;
    end
  endtask

  task automatic push_expected(input logic [7:0] base);
    word_t w;
    logic [7:0] a;
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < NW; i++) begin
      a      = base + 8'(i);
      w.data = model(mem[a]);
      w.filt = 8'(i / OS);
      w.last = (i == NW - 1);
      exp_q.push_back(w);
      addr_q.push_back(a);
    end
  endtask

  // One full drain; n counts clock edges since the edge that sampled start.
  task automatic run_drain(input vec_t v);
    int    words, reads, done_n, done_cnt, stall_cnt, prev_hs, bad_gap, exp_gap;
    bit    fin;
    word_t w;
    words = 0; reads = 0; done_n = -1; done_cnt = 0; stall_cnt = 0;
    prev_hs = 0; bad_gap = 0; fin = 0;
    fill_mem(v.base, v.mode);
    push_expected(v.base);
    @(negedge clk);
    base_addr = v.base;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
        check({v.name, ":busy_e0"}, busy, 1);
        check({v.name, ":rd_en_e0"}, mem_rd_en, 1);
      end
      if (n == 1) check({v.name, ":valid_e1"}, out_valid, 0);
      if (n == 2) check({v.name, ":valid_e2"}, out_valid, 1);
      if (mem_rd_en) begin
        if (addr_q.size() > 0) check({v.name, ":rd_addr"}, mem_addr, addr_q.pop_front());
        else check({v.name, ":extra_read"}, 1, 0);
        if (reads < NW) rd_log[reads] = mem_addr;
        reads++;
      end
      if (done_cnt > 0) check({v.name, ":busy_after"}, busy, 0);
      if (done) begin
        done_cnt++;
        done_n = n;
        check({v.name, ":busy_with_done"}, busy, 1);
        if (v.ign_start) start = 1'b1;
      end
      if (out_valid) begin
        if (v.ign_start && words == 10) start = 1'b1;
        if (words == v.stall_word && stall_cnt < v.stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
          if (exp_q.size() > 0) check({v.name, ":stall_data"}, out_data, exp_q[0].data);
          check({v.name, ":stall_no_rd"}, mem_rd_en, 0);
        end else begin
          out_ready = 1'b1;
          exp_gap = (words == v.stall_word) ? 3 + v.stall_len : 3;
          if (n + 1 - prev_hs != exp_gap) bad_gap++;
          prev_hs = n + 1;
          if (exp_q.size() == 0) check({v.name, ":underflow"}, 1, 0);
          else begin
            w = exp_q.pop_front();
            check({v.name, ":data"}, out_data, w.data);
            check({v.name, ":filter"}, out_filter, w.filt);
            check({v.name, ":last"}, out_last, w.last);
          end
          if (words < NW) got_data[words] = out_data;
          words++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done_cnt > 0 && n >= done_n + 6) fin = 1;
    end
    check({v.name, ":words"}, words, NW);
    check({v.name, ":reads"}, reads, NW);
    check({v.name, ":done_cnt"}, done_cnt, 1);
    check({v.name, ":done_cycle"}, done_n, v.exp_done_n);
    check({v.name, ":gaps"}, bad_gap, 0);
    check({v.name, ":sb_empty"}, exp_q.size(), 0);
  endtask

  vec_t vecs [5];
  int   hs_cnt;
  bit   hit;

  initial begin
    vecs[0] = '{"basic",   8'h20, 0, -1, 0, 1'b0, 192};
    vecs[1] = '{"bp",      8'h20, 0,  7, 5, 1'b0, 197};
    vecs[2] = '{"wrap",    8'hF8, 1, -1, 0, 1'b0, 192};
    vecs[3] = '{"ignst",   8'h20, 1, -1, 0, 1'b1, 192};
    vecs[4] = '{"relu",    8'h40, 2, -1, 0, 1'b0, 192};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0;
    #1;
    check("rst:rd_en", mem_rd_en, 0);
    check("rst:addr", mem_addr, 0);
    check("rst:valid", out_valid, 0);
    check("rst:data", out_data, 0);
    check("rst:filter", out_filter, 0);
    check("rst:last", out_last, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_drain(vecs[i]);
      if (vecs[i].mode == 1 && vecs[i].base == 8'hF8) begin
        check("wrap:addr8", rd_log[8], 8'h00);
        check("wrap:addr63", rd_log[63], 8'h37);
      end
      if (vecs[i].mode == 2) begin
`ifdef CONV_RESULT_RELU_EN
        check("relu:w0", got_data[0], 8'h00);
`else
        check("relu:w0", got_data[0], 8'h85);
`endif
        check("relu:w1", got_data[1], 8'h7F);
        check("relu:w2", got_data[2], 8'h00);
      end
    end

    // Reset in the middle of a drain, while word 20 is on the bus.
    fill_mem(8'h20, 0);
    @(negedge clk);
    base_addr = 8'h20; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs_cnt = 0; hit = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      if (out_valid && hs_cnt == 20) hit = 1;
      else begin
        if (out_valid) hs_cnt++;
        @(negedge clk);
      end
    end
    check("midrst:reached_w20", hit, 1);
    check("midrst:data_w20", out_data, 8'd20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:rd_en", mem_rd_en, 0);
    check("midrst:addr", mem_addr, 0);
    check("midrst:valid", out_valid, 0);
    check("midrst:data", out_data, 0);
    check("midrst:filter", out_filter, 0);
    check("midrst:last", out_last, 0);
    check("midrst:busy", busy, 0);
    check("midrst:done", done, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("midrst:no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst:idle_done", done, 0);
    check("midrst:idle_busy", busy, 0);
    run_drain(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
